ksm_term_writer: RTL and testbench



---
 rtl/ksm_term_writer_if.sv | 21 ++
 rtl/ksm_term_writer.sv | 227 ++++++++++++++++++++++
 tb/tb_ksm_term_writer.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ksm_term_writer_if.sv
// Wishbone master bundle between ksm_term_writer and the text VGA adapter's video RAM port.
interface ksm_term_writer_if;
  logic [15:0] wbm_adr_o;
  logic [15:0] wbm_dat_o;
  logic [15:0] wbm_dat_i;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [1:0]  wbm_sel_o;
  logic        wbm_ack_i;

  modport master (
    output wbm_adr_o, wbm_dat_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o,
    input  wbm_dat_i, wbm_ack_i
  );

  modport slave (
    input  wbm_adr_o, wbm_dat_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o,
    output wbm_dat_i, wbm_ack_i
  );
endinterface

// File: rtl/ksm_term_writer.sv
// Terminal output engine: byte stream -> glyph writes, control codes and scrolling in text VRAM.
// Optional feature: define KSM_TERM_TAB_EN to make 0x09 an 8-column tab instead of a glyph.
module ksm_term_writer #(
  parameter logic [15:0] BASE_ADR  = 16'o0,
  parameter int unsigned COLS      = 80,
  parameter int unsigned ROWS      = 25,
  parameter int unsigned FIRST_ROW = 1,
  parameter logic [24:0] FLASH_DIV = 25'd12500000
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [7:0]        char_i,
  input  logic              char_valid_i,
  output logic              char_ready_o,
  ksm_term_writer_if.master wbm,
  output logic [10:0]       cursor_o,
  output logic              cursor_on_o,
  output logic              flash_o
);

  typedef enum logic [2:0] {IDLE, PUTC, SC_RD, SC_WR, CLR, FIN} state_t;

  localparam int unsigned COL_W = $clog2(COLS);
  localparam int unsigned ROW_W = $clog2(ROWS);
  localparam logic [ROW_W-1:0] ROW_FIRST  = ROW_W'(FIRST_ROW);
  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST   = COL_W'(COLS - 1);
  localparam logic [9:0]       W_HALF     = 10'(COLS / 2);
  localparam logic [9:0]       W_FIRST    = 10'(FIRST_ROW * COLS / 2);
  localparam logic [9:0]       W_SC_LAST  = 10'((ROWS - 1) * COLS / 2 - 1);
  localparam logic [9:0]       W_LAST_ROW = 10'((ROWS - 1) * COLS / 2);
  localparam logic [9:0]       W_END      = 10'(ROWS * COLS / 2 - 1);

  state_t           state_q;
  logic [ROW_W-1:0] row_q;
  logic [COL_W-1:0] col_q;
  logic [7:0]       ch_q;
  logic [9:0]       w_q;
  logic [15:0]      rd_q;
  logic             home_q;
  logic             cyc_q;
  logic             we_q;
  logic [1:0]       sel_q;
  logic [15:0]      adr_q;
  logic [15:0]      dat_q;
  logic [10:0]      cursor_q;
  logic             flash_q;
  logic [24:0]      flash_cnt_q;

  logic [10:0] cursor_d;
  logic [9:0]  word_sel;
  logic [15:0] req_adr;
  logic [15:0] req_dat;
  logic        req_we;
  logic [1:0]  req_sel;
  logic        last_row;

  assign cursor_d = 11'(32'(row_q) * COLS + 32'(col_q));
  assign last_row = (row_q == ROW_LAST);

`ifdef KSM_TERM_TAB_EN
  logic [COL_W:0] tab_col;
  assign tab_col = ({1'b0, col_q} | (COL_W+1)'(7)) + (COL_W+1)'(1);
`endif

  // Request fields for the transfer the current state is about to issue.
  always_comb begin
    word_sel = (state_q == SC_RD) ? w_q + W_HALF : w_q;
    req_adr  = BASE_ADR + {5'b0, word_sel, 1'b0};
    req_dat  = 16'h2020;
    req_we   = 1'b1;
    req_sel  = 2'b11;
    case (state_q)
      PUTC: begin
        req_adr = BASE_ADR + {5'b0, cursor_d};
        req_dat = {ch_q, ch_q};
        req_sel = cursor_d[0] ? 2'b10 : 2'b01;
      end
      SC_RD:   req_we  = 1'b0;
      SC_WR:   req_dat = rd_q;
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= IDLE;
      row_q       <= ROW_FIRST;
      col_q       <= '0;
      ch_q        <= '0;
      w_q         <= '0;
      rd_q        <= '0;
      home_q      <= 1'b0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      cursor_q    <= 11'(FIRST_ROW * COLS);
      flash_q     <= 1'b1;
      flash_cnt_q <= '0;
    end else begin
      cursor_q <= cursor_d;
      if (flash_cnt_q == FLASH_DIV - 25'd1) begin
        flash_cnt_q <= '0;
        flash_q     <= ~flash_q;
      end else begin
        flash_cnt_q <= flash_cnt_q + 25'd1;
      end

      case (state_q)
        IDLE: if (char_valid_i) begin
          ch_q    <= char_i;
          state_q <= FIN;
          case (char_i)
            8'h0D: col_q <= '0;
            8'h0A: begin
              if (last_row) begin
                state_q <= SC_RD;
                w_q     <= W_FIRST;
                home_q  <= 1'b0;
              end else begin
                row_q <= row_q + ROW_W'(1);
              end
            end
            8'h08: if (col_q != '0) col_q <= col_q - COL_W'(1);
            8'h0C: begin
              state_q <= CLR;
              w_q     <= W_FIRST;
              home_q  <= 1'b1;
            end
`ifdef KSM_TERM_TAB_EN
            8'h09: begin
              if (tab_col >= (COL_W+1)'(COLS)) begin
                col_q <= '0;
                if (last_row) begin
                  state_q <= SC_RD;
                  w_q     <= W_FIRST;
                  home_q  <= 1'b0;
                end else begin
                  row_q <= row_q + ROW_W'(1);
                end
              end else begin
                col_q <= tab_col[COL_W-1:0];
              end
            end
`endif
            default: state_q <= PUTC;
          endcase
        end

        // Entry cycle is the idle gap; the request is raised one cycle later and held until ack.
        PUTC, SC_RD, SC_WR, CLR: begin
          if (!cyc_q) begin
            cyc_q <= 1'b1;
            we_q  <= req_we;
            sel_q <= req_sel;
            adr_q <= req_adr;
            dat_q <= req_dat;
          end else if (wbm.wbm_ack_i) begin
            cyc_q <= 1'b0;
            we_q  <= 1'b0;
            case (state_q)
              PUTC: begin
                if (col_q == COL_LAST) begin
                  col_q <= '0;
                  if (last_row) begin
                    state_q <= SC_RD;
                    w_q     <= W_FIRST;
                    home_q  <= 1'b0;
                  end else begin
                    row_q   <= row_q + ROW_W'(1);
                    state_q <= FIN;
                  end
                end else begin
                  col_q   <= col_q + COL_W'(1);
                  state_q <= FIN;
                end
              end
              SC_RD: begin
                rd_q    <= wbm.wbm_dat_i;
                state_q <= SC_WR;
              end
              SC_WR: begin
                if (w_q == W_SC_LAST) begin
                  w_q     <= W_LAST_ROW;
                  state_q <= CLR;
                end else begin
                  w_q     <= w_q + 10'd1;
                  state_q <= SC_RD;
                end
              end
              CLR: begin
                if (w_q == W_END) begin
                  state_q <= FIN;
                  if (home_q) begin
                    row_q <= ROW_FIRST;
                    col_q <= '0;
                  end
                end else begin
                  w_q <= w_q + 10'd1;
                end
              end
              default: ;
            endcase
          end
        end

        FIN:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wbm.wbm_cyc_o = cyc_q;
  assign wbm.wbm_stb_o = cyc_q;
  assign wbm.wbm_we_o  = we_q;
  assign wbm.wbm_sel_o = sel_q;
  assign wbm.wbm_adr_o = adr_q;
  assign wbm.wbm_dat_o = dat_q;

  assign char_ready_o = (state_q == IDLE);
  assign cursor_on_o  = (state_q == IDLE);
  assign cursor_o     = cursor_q;
  assign flash_o      = flash_q;

endmodule

// File: tb/tb_ksm_term_writer.sv
// Bench for ksm_term_writer: Wishbone VRAM slave with random ack delay plus a screen-level model.
module tb_ksm_term_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  char_b;
  logic        char_valid;
  logic        char_ready;
  logic [10:0] cursor;
  logic        cursor_on;
  logic        flash;

  always #5 clk = ~clk;

  ksm_term_writer_if bus ();

  ksm_term_writer #(
    .BASE_ADR (16'h0000),
    .COLS     (80),
    .ROWS     (25),
    .FIRST_ROW(1),
    .FLASH_DIV(25'd4)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .char_i      (char_b),
    .char_valid_i(char_valid),
    .char_ready_o(char_ready),
    .wbm         (bus.master),
    .cursor_o    (cursor),
    .cursor_on_o (cursor_on),
    .flash_o     (flash)
  );

  typedef struct {
    logic [15:0] adr;
    logic [15:0] dat;
    logic        we;
    logic [1:0]  sel;
    int          rise;
    int          ackc;
  } xact_t;

  int tests = 0;
  int fails = 0;

  logic [7:0] vmem [0:2047];
  logic [7:0] scr  [0:1999];
  int mrow, mcol;

  xact_t log_q[$];
  int cyc_n = 0;
  int prot_err = 0;
  int on_busy_err = 0;
  int min_delay = 0, max_delay = 0;
  int ack_cnt = 0, cur_delay = 0, rise_cyc = 0;
  logic prev_cyc = 1'b0;
  logic [15:0] h_adr, h_dat;
  logic h_we;
  logic [1:0] h_sel;
  logic last_busy;

  always @(posedge clk) cyc_n++;

  // Slave + protocol monitor, all on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      bus.wbm_ack_i = 1'b0;
      bus.wbm_dat_i = 16'h0000;
      ack_cnt  = 0;
      prev_cyc = 1'b0;
    end else begin
      if (bus.wbm_stb_o !== bus.wbm_cyc_o) prot_err++;
      if (bus.wbm_cyc_o === 1'b1 && cursor_on !== 1'b0) on_busy_err++;
      if (bus.wbm_ack_i) begin
        if (bus.wbm_cyc_o !== 1'b0) prot_err++;
        bus.wbm_ack_i = 1'b0;
        ack_cnt = 0;
      end else if (bus.wbm_cyc_o === 1'b1) begin
        if (!prev_cyc) begin
          rise_cyc  = cyc_n;
          cur_delay = int'($urandom_range(max_delay, min_delay));
          ack_cnt   = 0;
          h_adr = bus.wbm_adr_o; h_dat = bus.wbm_dat_o; h_we = bus.wbm_we_o; h_sel = bus.wbm_sel_o;
        end else if (h_adr !== bus.wbm_adr_o || h_dat !== bus.wbm_dat_o ||
                     h_we !== bus.wbm_we_o || h_sel !== bus.wbm_sel_o) begin
          prot_err++;
        end
        if (ack_cnt == cur_delay) begin
          automatic logic [15:0] a = bus.wbm_adr_o;
          automatic logic [10:0] b = {a[10:1], 1'b0};
          automatic logic [15:0] d = bus.wbm_dat_o;
          if (a > 16'd1999) begin
            prot_err++;
          end else if (bus.wbm_we_o) begin
            if (bus.wbm_sel_o[0]) vmem[b] = d[7:0];
            if (bus.wbm_sel_o[1]) vmem[b + 11'd1] = d[15:8];
          end else begin
            d = {vmem[b + 11'd1], vmem[b]};
            bus.wbm_dat_i = d;
          end
          log_q.push_back('{a, d, bus.wbm_we_o, bus.wbm_sel_o, rise_cyc, cyc_n});
          bus.wbm_ack_i = 1'b1;
        end else begin
          ack_cnt++;
        end
      end
      prev_cyc = bus.wbm_cyc_o;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- screen model ----------------
  task automatic model_lf();
    if (mrow == 24) begin
      for (int i = 80; i < 1920; i++) scr[i] = scr[i + 80];
      for (int i = 1920; i < 2000; i++) scr[i] = 8'h20;
    end else begin
      mrow++;
    end
  endtask

  task automatic model_putc(input logic [7:0] c);
    case (c)
      8'h0D: mcol = 0;
      8'h0A: model_lf();
      8'h08: if (mcol > 0) mcol--;
      8'h0C: begin
        for (int i = 80; i < 2000; i++) scr[i] = 8'h20;
        mrow = 1;
        mcol = 0;
      end
`ifdef KSM_TERM_TAB_EN
      8'h09: begin
        mcol = (mcol | 7) + 1;
        if (mcol >= 80) begin
          mcol = 0;
          model_lf();
        end
      end
`endif
      default: begin
        scr[mrow * 80 + mcol] = c;
        if (mcol == 79) begin
          mcol = 0;
          model_lf();
        end else begin
          mcol++;
        end
      end
    endcase
  endtask

  task automatic send_char(input logic [7:0] c);
    int n;
    @(negedge clk);
    n = 0;
    while (char_ready !== 1'b1 && n < 20000) begin @(negedge clk); n++; end
    char_b = c;
    char_valid = 1'b1;
    @(negedge clk);
    char_valid = 1'b0;
    last_busy = (char_ready === 1'b0) && (cursor_on === 1'b0);
    n = 0;
    while (char_ready !== 1'b1 && n < 20000) begin @(negedge clk); n++; end
    if (n >= 20000) begin
      tests++; fails++;
      $display("FAIL send_timeout: char %02h still busy, required ready within 20000 cycles", c);
    end
    model_putc(c);
  endtask

  task automatic check_state(input string name);
    int diffs = 0, first = 0;
    for (int i = 0; i < 2000; i++) begin
      if (vmem[i] !== scr[i]) begin
        if (diffs == 0) first = i;
        diffs++;
      end
    end
    tests++;
    if (diffs != 0) begin
      fails++;
      $display("FAIL %s_screen: %0d bytes differ, byte %0d got %02h required %02h",
               name, diffs, first, vmem[first], scr[first]);
    end
    tests++;
    if (cursor !== 11'(mrow * 80 + mcol)) begin
      fails++;
      $display("FAIL %s_cursor: got %0d required %0d", name, cursor, mrow * 80 + mcol);
    end
    tests++;
    if (prot_err !== 0) begin
      fails++;
      $display("FAIL %s_protocol: got %0d violations required 0", name, prot_err);
    end
    prot_err = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    tests++; if (cursor !== 11'd80) begin fails++; $display("FAIL reset_cursor: got %0d required 80", cursor); end
    tests++; if (cursor_on !== 1'b1) begin fails++; $display("FAIL reset_cursor_on: got %b required 1", cursor_on); end
    tests++; if (flash !== 1'b1) begin fails++; $display("FAIL reset_flash: got %b required 1", flash); end
    tests++; if (char_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b required 1", char_ready); end
    tests++;
    if ({bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_sel_o} !== 5'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got cyc/stb/we/sel %b required 00000",
               {bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_sel_o});
    end
    tests++;
    if ({bus.wbm_adr_o, bus.wbm_dat_o} !== 32'h0) begin
      fails++;
      $display("FAIL reset_adr_dat: got %h/%h required 0000/0000", bus.wbm_adr_o, bus.wbm_dat_o);
    end
  endtask

  task automatic test_first_glyph();
    log_q.delete();
    on_busy_err = 0;
    send_char(8'h41);
    tests++; if (log_q.size() !== 1) begin fails++; $display("FAIL glyph_count: got %0d required 1", log_q.size()); end
    tests++;
    if (log_q[0].adr !== 16'h0050 || log_q[0].sel !== 2'b01 || log_q[0].dat !== 16'h4141 || log_q[0].we !== 1'b1) begin
      fails++;
      $display("FAIL glyph_xact: got adr %h sel %b dat %h we %b required 0050 01 4141 1",
               log_q[0].adr, log_q[0].sel, log_q[0].dat, log_q[0].we);
    end
    tests++; if (cursor !== 11'd81) begin fails++; $display("FAIL glyph_cursor: got %0d required 81", cursor); end
    tests++; if (last_busy !== 1'b1) begin fails++; $display("FAIL glyph_busy: got %b required 1", last_busy); end
    tests++; if (on_busy_err !== 0) begin fails++; $display("FAIL glyph_cursor_on: got %0d cycles shown during bus cycle required 0", on_busy_err); end
    check_state("first_glyph");
  endtask

  task automatic test_row_fill();
    xact_t x;
    log_q.delete();
    for (int i = 0; i < 79; i++) send_char(8'h42);
    x = log_q[log_q.size() - 1];
    tests++; if (log_q.size() !== 79) begin fails++; $display("FAIL fill_count: got %0d required 79", log_q.size()); end
    tests++;
    if (x.adr !== 16'h009F || x.sel !== 2'b10 || x.dat !== 16'h4242) begin
      fails++;
      $display("FAIL fill_last: got adr %h sel %b dat %h required 009F 10 4242", x.adr, x.sel, x.dat);
    end
    tests++; if (cursor !== 11'd160) begin fails++; $display("FAIL fill_cursor: got %0d required 160", cursor); end
    check_state("row_fill");
  endtask

  task automatic test_flash();
    int last_t = -1, tog = 0, bad = 0;
    logic pf;
    @(negedge clk);
    pf = flash;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (flash !== pf) begin
        if (last_t >= 0 && k - last_t != 4) bad++;
        last_t = k;
        tog++;
        pf = flash;
      end
    end
    tests++; if (bad !== 0) begin fails++; $display("FAIL flash_period: got %0d wrong intervals required 0", bad); end
    tests++; if (tog < 5) begin fails++; $display("FAIL flash_toggles: got %0d toggles in 24 cycles required >=5", tog); end
  endtask

  task automatic test_backspace();
    log_q.delete();
    send_char(8'h08);
    tests++; if (cursor !== 11'd160) begin fails++; $display("FAIL bs_col0: got %0d required 160", cursor); end
    send_char(8'h78);
    send_char(8'h79);
    send_char(8'h08);
    tests++; if (cursor !== 11'd161) begin fails++; $display("FAIL bs_back: got %0d required 161", cursor); end
    tests++; if (log_q.size() !== 2) begin fails++; $display("FAIL bs_writes: got %0d writes required 2", log_q.size()); end
    check_state("backspace");
  endtask

  task automatic test_tab();
    int base;
    send_char(8'h0D);
    send_char(8'h61); send_char(8'h62); send_char(8'h63);
    base = mrow * 80;
    log_q.delete();
    send_char(8'h09);
`ifdef KSM_TERM_TAB_EN
    tests++; if (log_q.size() !== 0) begin fails++; $display("FAIL tab_bus: got %0d transfers required 0", log_q.size()); end
    tests++; if (cursor !== 11'(base + 8)) begin fails++; $display("FAIL tab_cursor: got %0d required %0d", cursor, base + 8); end
`else
    tests++; if (log_q.size() !== 1) begin fails++; $display("FAIL tab_glyph: got %0d transfers required 1", log_q.size()); end
    tests++; if (log_q[0].dat !== 16'h0909) begin fails++; $display("FAIL tab_dat: got %h required 0909", log_q[0].dat); end
    tests++; if (cursor !== 11'(base + 4)) begin fails++; $display("FAIL tab_cursor: got %0d required %0d", cursor, base + 4); end
`endif
    check_state("tab");
  endtask

  task automatic test_random_text();
    logic [7:0] c;
    max_delay = 3;
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(15, 0))
        0: c = 8'h0D;
        1: c = 8'h0A;
        2: c = 8'h08;
        3: c = 8'h09;
        default: begin
          c = 8'($urandom);
          if (c == 8'h0C) c = 8'h41;
        end
      endcase
      send_char(c);
    end
    check_state("random_text");
  endtask

  task automatic goto_last_row();
    send_char(8'h0D);
    while (mrow < 24) send_char(8'h0A);
  endtask

  task automatic test_scroll();
    int seq_bad = 0, gap_bad = 0;
    max_delay = 3;
    goto_last_row();
    log_q.delete();
    on_busy_err = 0;
    send_char(8'h0A);
    tests++; if (log_q.size() !== 1880) begin fails++; $display("FAIL scroll_count: got %0d transfers required 1880", log_q.size()); end
    for (int i = 0; i < 920 && 2 * i + 1 < log_q.size(); i++) begin
      if (log_q[2*i].we !== 1'b0 || log_q[2*i].adr !== 16'(2 * (80 + i)) || log_q[2*i].sel !== 2'b11) seq_bad++;
      if (log_q[2*i+1].we !== 1'b1 || log_q[2*i+1].adr !== 16'(2 * (40 + i)) ||
          log_q[2*i+1].sel !== 2'b11 || log_q[2*i+1].dat !== log_q[2*i].dat) seq_bad++;
    end
    for (int j = 0; j < 40 && 1840 + j < log_q.size(); j++) begin
      if (log_q[1840+j].we !== 1'b1 || log_q[1840+j].adr !== 16'(16'h0780 + 2 * j) ||
          log_q[1840+j].dat !== 16'h2020 || log_q[1840+j].sel !== 2'b11) seq_bad++;
    end
    for (int i = 1; i < log_q.size(); i++)
      if (log_q[i].rise - log_q[i-1].ackc != 2) gap_bad++;
    tests++; if (seq_bad !== 0) begin fails++; $display("FAIL scroll_seq: got %0d wrong transfers required 0", seq_bad); end
    tests++; if (gap_bad !== 0) begin fails++; $display("FAIL scroll_gap: got %0d wrong idle gaps required 0", gap_bad); end
    tests++; if (cursor !== 11'd1920) begin fails++; $display("FAIL scroll_cursor: got %0d required 1920", cursor); end
    tests++; if (on_busy_err !== 0) begin fails++; $display("FAIL scroll_cursor_on: got %0d shown cycles required 0", on_busy_err); end
    check_state("scroll");
  endtask

  task automatic test_wrap_scroll();
    max_delay = 1;
    for (int i = 0; i < 80; i++) send_char(8'($urandom_range(8'h7E, 8'h20)));
    tests++; if (cursor !== 11'd1920) begin fails++; $display("FAIL wrap_cursor: got %0d required 1920", cursor); end
    check_state("wrap_scroll");
  endtask

  task automatic test_clear();
    int bad = 0;
    max_delay = 2;
    log_q.delete();
    send_char(8'h0C);
    tests++; if (log_q.size() !== 960) begin fails++; $display("FAIL clear_count: got %0d required 960", log_q.size()); end
    for (int k = 0; k < log_q.size(); k++)
      if (log_q[k].adr !== 16'(16'h0050 + 2 * k) || log_q[k].dat !== 16'h2020 ||
          log_q[k].we !== 1'b1 || log_q[k].sel !== 2'b11) bad++;
    tests++; if (bad !== 0) begin fails++; $display("FAIL clear_seq: got %0d wrong transfers required 0", bad); end
    tests++; if (cursor !== 11'd80) begin fails++; $display("FAIL clear_cursor: got %0d required 80", cursor); end
    check_state("clear");
  endtask

  task automatic test_reset_mid();
    int n = 0;
    min_delay = 3; max_delay = 3;
    goto_last_row();
    log_q.delete();
    @(negedge clk);
    char_b = 8'h0A; char_valid = 1'b1;
    @(negedge clk);
    char_valid = 1'b0;
    while (!(log_q.size() >= 6 && bus.wbm_cyc_o === 1'b1 && bus.wbm_we_o === 1'b0) && n < 2000) begin
      @(negedge clk); n++;
    end
    tests++; if (n >= 2000) begin fails++; $display("FAIL rstmid_wait: got no read cycle required one within 2000 cycles"); end
    #2 rst = 1'b1;
    #1;
    tests++; if (bus.wbm_cyc_o !== 1'b0) begin fails++; $display("FAIL rstmid_cyc: got %b required 0", bus.wbm_cyc_o); end
    tests++; if (bus.wbm_stb_o !== 1'b0) begin fails++; $display("FAIL rstmid_stb: got %b required 0", bus.wbm_stb_o); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++; if (cursor !== 11'd80) begin fails++; $display("FAIL rstmid_cursor: got %0d required 80", cursor); end
    tests++; if (char_ready !== 1'b1) begin fails++; $display("FAIL rstmid_ready: got %b required 1", char_ready); end
    tests++; if (cursor_on !== 1'b1) begin fails++; $display("FAIL rstmid_cursor_on: got %b required 1", cursor_on); end
    for (int i = 0; i < 2000; i++) scr[i] = vmem[i];
    mrow = 1; mcol = 0;
    min_delay = 0; max_delay = 2;
    prot_err = 0;
    log_q.delete();
    send_char(8'h5A);
    tests++; if (log_q[0].adr !== 16'h0050) begin fails++; $display("FAIL rstmid_resume: got adr %h required 0050", log_q[0].adr); end
    check_state("reset_mid");
  endtask

  initial begin
    rst = 1'b1;
    char_b = 8'h00;
    char_valid = 1'b0;
    for (int i = 0; i < 2048; i++) vmem[i] = 8'($urandom);
    for (int i = 0; i < 2000; i++) scr[i] = vmem[i];
    mrow = 1; mcol = 0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_first_glyph();
    test_row_fill();
    test_flash();
    test_backspace();
    test_tab();
    test_random_text();
    test_scroll();
    test_wrap_scroll();
    test_clear();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
